operand_skew_feeder: RTL and testbench
======================================

// Module: operand_skew_feeder
// PURPOSE
//  Consumer (pop) side of the per-row operand FIFOs. Drains LANES FIFOs into the west edge of the systolic PE array.
//  Output is diagonally skewed: lane i starts i steps after lane 0.
//  Stalls the whole wavefront when any lane that must pop this step has an empty FIFO.
// PARAMETERS
//  LANES   32  number of FIFO lanes / PE rows
//  BWIDTH  8   operand width (INT8)
//  LEN_W   8   width of LEN; LANES <= 2**LEN_W
// PORTS
//  CLK        in   1             clock
//  RSTn       in   1             reset, asynchronous, active-low
//  START      in   1             1-cycle pulse; sampled only in IDLE
//  LEN        in   LEN_W         elements per lane for this job; sampled with START
//  FIFO_EMPTY in   LANES         IS_EMPTY of each lane FIFO
//  FIFO_DATA  in   LANES*BWIDTH  D_out of each lane FIFO; lane i = bits [i*BWIDTH +: BWIDTH]
//  FIFO_POP   out  LANES         POPE to each lane FIFO (combinational)
//  A_OUT      out  LANES*BWIDTH  registered operands to PE array
//  A_VLD      out  LANES         registered per-lane valid
//  ARRAY_EN   out  1             registered; 1 = array advances this cycle
//  BUSY       out  1             high in RUN
//  DONE       out  1             1-cycle pulse at job end
// BEHAVIOUR
//  Reset values: all registered outputs 0, state IDLE, step counter 0. FIFO_POP is 0 while in reset.
//  FSM states:
//   IDLE -> RUN when START=1 and LEN!=0. LEN and step t=0 are latched.
//   IDLE -> FIN when START=1 and LEN==0. No pops occur.
//   RUN  -> FIN after step t = LEN+LANES-2 advances.
//   FIN  -> IDLE after one cycle, with DONE=1 during FIN.
//  Lane i is active at step t iff i <= t < i+LEN. Step counter width is LEN_W+1 bits.
//  stall = RUN & |(active & FIFO_EMPTY).
//  FIFO_POP[i] = RUN & active[i] & ~stall. Pop and data capture happen in the same cycle, because FIFO D_out is combinational.
//  On an advancing cycle (RUN & ~stall), the next edge loads:
//   A_OUT[i] = active ? FIFO_DATA[i] : 0
//   A_VLD = active
//   ARRAY_EN = 1
//   t = t+1
//  On a stall or outside RUN, the next edge loads: A_OUT = 0, A_VLD = 0, ARRAY_EN = 0, and t holds.
//  Latency: data popped in cycle c is visible at A_OUT in cycle c+1.
//  With no stalls, DONE is in cycle LEN+LANES after the START edge, coincident with the last valid output.
//  START outside IDLE is ignored; LEN changes mid-job are ignored.
//  Inactive lanes never pop, even if their FIFO is non-empty.
//  Stalls extend the job by exactly the number of stall cycles; skew is preserved.
//  RSTn low mid-job aborts to IDLE with no DONE. FIFO contents are untouched; the FIFOs have their own reset.
// CONFIGURATION
//  FEEDER_STALL_CNT_EN defined:
//   Adds output STALL_CNT [15:0]: count of stall cycles in the current job.
//   Cleared on job start; saturates at 16'hFFFF; holds after DONE until the next START. Reset value 0.
//  FEEDER_STALL_CNT_EN undefined: STALL_CNT port and counter are absent.
// STRUCTURE
//  Package systolic_pkg:
//   feeder_state_t {IDLE, RUN, FIN}
//   defaults BWIDTH=8, LANES=32
//   function lane_active(t, i, len)
//  Sub-module feeder_lane, one instance per lane:
//   active-window compare, FIFO_POP gating, A_OUT/A_VLD registers
//   inputs: t, len, advance, empty, data
//  Top level holds the FSM, step counter, stall reduction and the optional stall counter.
// TESTING (LANES=4, LEN_W=8; cycle 1 = first cycle after the START edge)
//  1. All FIFOs prefilled with 3 entries, START with LEN=3:
//     lane0 pops in cycles 1-3, lane3 pops in cycles 4-6; A_VLD[0] high in cycles 2-4, A_VLD[3] high in cycles 5-7.
//     DONE in cycle 7; FIFOs empty at end.
//  2. Lane2 FIFO empty at step 2, refilled 2 cycles later:
//     2 cycles of FIFO_POP=0 and ARRAY_EN=0; DONE delayed to cycle 9.
//     A_OUT order matches push order; with the macro defined, STALL_CNT=2.
//  3. START with LEN=0: no pops; DONE in cycle 1; BUSY never high.
//  4. START re-pulsed in cycle 3 with LEN=5: ignored; job still ends after 3 elements per lane.
//  5. RSTn asserted in cycle 4: all outputs 0 asynchronously, no DONE.
//     A fresh START after reset release runs a full job on the remaining FIFO data.
//  6. Lane data 8'hFF / 8'h80 (full width): passed unchanged; inactive lanes output 8'h00 with A_VLD=0.

Source files
------------

// File: rtl/operand_skew_feeder_pkg.sv
// Shared types and helpers for the systolic operand feeder.
// State encoding, default widths and the lane active-window test.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } feeder_state_t;

  localparam int BWIDTH_DEF = 8;
  localparam int LANES_DEF  = 32;

  // Lane i owns steps [i, i+len) of the skewed wavefront.
  function automatic logic lane_active(
    input int unsigned t,
    input int unsigned i,
    input int unsigned len
  );
    return (t >= i) && (t < i + len);
  endfunction

endpackage

// File: rtl/operand_skew_feeder_lane.sv
// One feeder lane: active-window test, pop gating, output registers.
// Ports: t/len window, advance, FIFO empty/data in; starve, pop, a_out, a_vld out.
module feeder_lane
  import systolic_pkg::*;
#(
  parameter int BWIDTH = BWIDTH_DEF,
  parameter int LEN_W  = 8,
  parameter int IDX    = 0
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic [LEN_W:0]    t,
  input  logic [LEN_W-1:0]  len,
  input  logic              advance,
  input  logic              empty,
  input  logic [BWIDTH-1:0] data,
  output logic              starve,
  output logic              pop,
  output logic [BWIDTH-1:0] a_out,
  output logic              a_vld
);

  logic active;

  assign active = lane_active(32'(t), 32'(IDX), 32'(len));
  assign starve = active & empty;
  assign pop    = advance & active;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      a_out <= '0;
      a_vld <= 1'b0;
    end else if (advance) begin
      a_out <= active ? data : '0;
      a_vld <= active;
    end else begin
      a_out <= '0;
      a_vld <= 1'b0;
    end
  end

endmodule

// File: rtl/operand_skew_feeder.sv
// Pops LANES operand FIFOs into a systolic array with diagonal skew.
// Ports: CLK, RSTn, START/LEN job control, FIFO_EMPTY/FIFO_DATA in,
// FIFO_POP out, A_OUT/A_VLD/ARRAY_EN to the array, BUSY, DONE.
// Optional FEEDER_STALL_CNT_EN adds STALL_CNT[15:0], stall cycles per job.
module operand_skew_feeder
  import systolic_pkg::*;
#(
  parameter int LANES  = LANES_DEF,
  parameter int BWIDTH = BWIDTH_DEF,
  parameter int LEN_W  = 8
) (
  input  logic                    CLK,
  input  logic                    RSTn,
  input  logic                    START,
  input  logic [LEN_W-1:0]        LEN,
  input  logic [LANES-1:0]        FIFO_EMPTY,
  input  logic [LANES*BWIDTH-1:0] FIFO_DATA,
  output logic [LANES-1:0]        FIFO_POP,
  output logic [LANES*BWIDTH-1:0] A_OUT,
  output logic [LANES-1:0]        A_VLD,
  output logic                    ARRAY_EN,
  output logic                    BUSY,
  output logic                    DONE
`ifdef FEEDER_STALL_CNT_EN
  ,
  output logic [15:0]             STALL_CNT
`endif
);

  localparam logic [LEN_W:0] LAST_OFS = (LEN_W+1)'(LANES - 2);

  feeder_state_t    state_q;
  feeder_state_t    state_d;
  logic [LEN_W:0]   t_q;
  logic [LEN_W-1:0] len_q;
  logic [LANES-1:0] starve;
  logic             run;
  logic             stall;
  logic             advance;
  logic             start_go;
  logic             last_step;

  assign run       = (state_q == RUN);
  assign stall     = run & (|starve);
  assign advance   = run & ~stall;
  assign start_go  = (state_q == IDLE) & START;
  assign last_step = (t_q == ({1'b0, len_q} + LAST_OFS));
  assign BUSY      = run;
  assign DONE      = (state_q == FIN);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (START) state_d = (LEN != '0) ? RUN : FIN;
      RUN:  if (advance && last_step) state_d = FIN;
      FIN:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q  <= IDLE;
      t_q      <= '0;
      len_q    <= '0;
      ARRAY_EN <= 1'b0;
    end else begin
      state_q  <= state_d;
      ARRAY_EN <= advance;
      if (start_go) begin
        t_q   <= '0;
        len_q <= LEN;
      end else if (advance) begin
        t_q <= t_q + 1'b1;
      end
    end
  end

`ifdef FEEDER_STALL_CNT_EN
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      STALL_CNT <= '0;
    end else if (start_go) begin
      STALL_CNT <= '0;
    end else if (stall && (STALL_CNT != 16'hFFFF)) begin
      STALL_CNT <= STALL_CNT + 16'd1;
    end
  end
`endif

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    feeder_lane #(
      .BWIDTH(BWIDTH),
      .LEN_W (LEN_W),
      .IDX   (i)
    ) u_lane (
      .CLK    (CLK),
      .RSTn   (RSTn),
      .t      (t_q),
      .len    (len_q),
      .advance(advance),
      .empty  (FIFO_EMPTY[i]),
      .data   (FIFO_DATA[i*BWIDTH +: BWIDTH]),
      .starve (starve[i]),
      .pop    (FIFO_POP[i]),
      .a_out  (A_OUT[i*BWIDTH +: BWIDTH]),
      .a_vld  (A_VLD[i])
    );
  end

endmodule

// File: tb/tb_operand_skew_feeder.sv
// Scoreboard bench for operand_skew_feeder with LANES=4.
// Lane FIFOs are modelled as queues; a monitor checks every output beat.
module tb_operand_skew_feeder;

  localparam int LANES = 4;
  localparam int BW    = 8;
  localparam int LW    = 8;

  logic              CLK = 1'b0;
  logic              RSTn = 1'b0;
  logic              START = 1'b0;
  logic [LW-1:0]     LEN = '0;
  logic [LANES-1:0]  fifo_empty;
  logic [LANES*BW-1:0] fifo_data;
  logic [LANES-1:0]  fifo_pop;
  logic [LANES*BW-1:0] a_out;
  logic [LANES-1:0]  a_vld;
  logic              array_en;
  logic              busy;
  logic              done;
`ifdef FEEDER_STALL_CNT_EN
  logic [15:0]       stall_cnt;
`endif

  always #5 CLK = ~CLK;

  operand_skew_feeder #(
    .LANES (LANES),
    .BWIDTH(BW),
    .LEN_W (LW)
  ) dut (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .START     (START),
    .LEN       (LEN),
    .FIFO_EMPTY(fifo_empty),
    .FIFO_DATA (fifo_data),
    .FIFO_POP  (fifo_pop),
    .A_OUT     (a_out),
    .A_VLD     (a_vld),
    .ARRAY_EN  (array_en),
    .BUSY      (busy),
    .DONE      (done)
`ifdef FEEDER_STALL_CNT_EN
    ,
    .STALL_CNT (stall_cnt)
`endif
  );

  typedef struct packed {
    logic [LANES-1:0]    vld;
    logic [LANES*BW-1:0] dat;
  } rec_t;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [BW-1:0] fq [LANES][$];
  logic [BW-1:0] jd [LANES][8];
  rec_t        exp_q [$];

  logic [LANES-1:0] s_pop, s_vld;
  logic        s_done, s_busy, s_en;
  int          r_done, r_zero_pop, r_zero_en, r_pops;
  logic        r_busy;
  logic [31:0] p0m, p3m, v0m, v3m;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < LANES; i++) begin
      fifo_empty[i] = (fq[i].size() == 0);
      fifo_data[i*BW +: BW] = fifo_empty[i] ? '0 : fq[i][0];
    end
  endtask

  task automatic push(input int ln, input logic [BW-1:0] v);
    fq[ln].push_back(v);
    refresh();
  endtask

  // Expected beats: lane i carries its element s-i at step s.
  task automatic push_exp(input int len, input int nsteps);
    rec_t r;
    for (int s = 0; s < nsteps; s++) begin
      r = '0;
      for (int i = 0; i < LANES; i++)
        if (s >= i && s < i + len) begin
          r.vld[i] = 1'b1;
          r.dat[i*BW +: BW] = jd[i][s-i];
        end
      exp_q.push_back(r);
    end
  endtask

  // Monitor: every negedge compares one beat against the scoreboard.
  always @(negedge CLK) begin
    rec_t e;
    if (array_en) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL beat_unexpected: got vld %0h expected none", a_vld);
      end else begin
        e = exp_q.pop_front();
        chk("beat_vld", 64'(a_vld), 64'(e.vld));
        chk("beat_out", 64'(a_out), 64'(e.dat));
      end
    end else begin
      chk("idle_beat", 64'({a_vld, a_out}), 64'd0);
    end
  end

  // One clock: sample at negedge, apply pops just after posedge.
  task automatic cyc_step();
    @(negedge CLK);
    s_pop  = fifo_pop;
    s_vld  = a_vld;
    s_done = done;
    s_busy = busy;
    s_en   = array_en;
    @(posedge CLK);
    #1;
    for (int i = 0; i < LANES; i++)
      if (s_pop[i]) begin
        if (fq[i].size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL underflow: lane %0d popped while empty", i);
        end else begin
          void'(fq[i].pop_front());
        end
      end
    refresh();
  endtask

  task automatic start(input int len);
    START = 1'b1;
    LEN = LW'(len);
    cyc_step();
    START = 1'b0;
  endtask

  task automatic run_job(input int len, input int rep_c, input int refill_c);
    r_done = 0; r_zero_pop = 0; r_zero_en = 0; r_pops = 0; r_busy = 0;
    p0m = '0; p3m = '0; v0m = '0; v3m = '0;
    start(len);
    for (int c = 1; c <= 60; c++) begin
      cyc_step();
      if (c < 32) begin
        p0m[c] = s_pop[0];
        p3m[c] = s_pop[3];
        v0m[c] = s_vld[0];
        v3m[c] = s_vld[3];
      end
      r_pops += $countones(s_pop);
      if (s_busy) begin
        r_busy = 1'b1;
        if (s_pop == '0) r_zero_pop++;
      end
      if (c >= 2 && !s_en) r_zero_en++;
      if (c == rep_c) begin
        START = 1'b1;
        LEN = 8'd5;
      end
      if (c == rep_c + 1) START = 1'b0;
      if (c == refill_c)
        for (int k = 0; k < 3; k++) push(2, jd[2][k]);
      if (s_done) begin
        r_done = c;
        break;
      end
    end
    START = 1'b0;
    if (r_done == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL done_timeout: got no DONE expected DONE within 60");
    end
  endtask

  task automatic fill3(input logic [BW-1:0] base);
    for (int i = 0; i < LANES; i++)
      for (int k = 0; k < 3; k++) begin
        jd[i][k] = base + BW'(i*16 + k);
        push(i, jd[i][k]);
      end
  endtask

  task automatic chk_fifos_empty(input string nm);
    logic [LANES-1:0] e;
    for (int i = 0; i < LANES; i++) e[i] = (fq[i].size() == 0);
    chk(nm, 64'(e), 64'hF);
  endtask

  initial begin
    logic [BW-1:0] nd [LANES][3];
    logic [LANES*8-1:0] sz;
    int dn;
    refresh();
    #12;
    chk("rst_outs", 64'({a_out, a_vld, array_en, busy, done}), 64'd0);
    START = 1'b1;
    #1;
    chk("rst_pop", 64'(fifo_pop), 64'd0);
`ifdef FEEDER_STALL_CNT_EN
    chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
`endif
    START = 1'b0;
    @(posedge CLK);
    #1;
    RSTn = 1'b1;
    cyc_step();

    // 1: plain job, LEN=3
    fill3(8'h10);
    push_exp(3, 6);
    run_job(3, 0, 0);
    chk("t1_done_cyc", 64'(r_done), 64'd7);
    chk("t1_pop0", 64'(p0m), 64'h0E);
    chk("t1_pop3", 64'(p3m), 64'h70);
    chk("t1_vld0", 64'(v0m), 64'h1C);
    chk("t1_vld3", 64'(v3m), 64'hE0);
    chk("t1_en_gaps", 64'(r_zero_en), 64'd0);
    chk_fifos_empty("t1_fifos");
    cyc_step();

    // 2: lane2 starved at step 2, refilled after two stall cycles
    for (int i = 0; i < LANES; i++)
      for (int k = 0; k < 3; k++) begin
        jd[i][k] = 8'hA0 + BW'(i*4 + k);
        if (i != 2) push(i, jd[i][k]);
      end
    push_exp(3, 6);
    run_job(3, 0, 4);
    chk("t2_done_cyc", 64'(r_done), 64'd9);
    chk("t2_pop_gaps", 64'(r_zero_pop), 64'd2);
    chk("t2_en_gaps", 64'(r_zero_en), 64'd2);
`ifdef FEEDER_STALL_CNT_EN
    chk("t2_stall_cnt", 64'(stall_cnt), 64'd2);
`endif
    chk_fifos_empty("t2_fifos");
    cyc_step();

    // 3: LEN=0 goes straight to DONE
    run_job(0, 0, 0);
    chk("t3_done_cyc", 64'(r_done), 64'd1);
    chk("t3_busy", 64'(r_busy), 64'd0);
    chk("t3_pops", 64'(r_pops), 64'd0);
    cyc_step();

    // 4: START re-pulsed mid-job with LEN=5
    fill3(8'h40);
    push_exp(3, 6);
    run_job(3, 2, 0);
    chk("t4_done_cyc", 64'(r_done), 64'd7);
    chk("t4_pop0", 64'(p0m), 64'h0E);
    chk("t4_pops", 64'(r_pops), 64'd12);
    chk_fifos_empty("t4_fifos");
    cyc_step();

    // 5: reset during cycle 4, then a full job on the leftovers
    fill3(8'h70);
    push_exp(3, 2);
    start(3);
    repeat (3) cyc_step();
    #1;
    RSTn = 1'b0;
    #1;
    chk("t5_rst_outs",
        64'({a_out, a_vld, array_en, busy, done, fifo_pop}), 64'd0);
    dn = 0;
    repeat (3) begin
      cyc_step();
      dn += int'(s_done) + int'(s_pop != '0);
    end
    chk("t5_no_done", 64'(dn), 64'd0);
    for (int i = 0; i < LANES; i++) sz[i*8 +: 8] = 8'(fq[i].size());
    chk("t5_left", 64'(sz), 64'h03020100);
    RSTn = 1'b1;
    cyc_step();
    for (int i = 0; i < LANES; i++)
      for (int k = 0; k < 3; k++)
        nd[i][k] = (k < i) ? jd[i][3-i+k] : 8'hC0 + BW'(i*4 + k);
    for (int i = 0; i < LANES; i++)
      for (int k = 0; k < 3; k++) begin
        jd[i][k] = nd[i][k];
        if (k >= i) push(i, nd[i][k]);
      end
    push_exp(3, 6);
    run_job(3, 0, 0);
    chk("t5_done_cyc", 64'(r_done), 64'd7);
    chk_fifos_empty("t5_fifos");
    cyc_step();

    // 6: full-width data, LEN=1, extra entries must stay put
    for (int i = 0; i < LANES; i++) begin
      jd[i][0] = (i % 2 == 0) ? 8'hFF : 8'h80;
      push(i, jd[i][0]);
      push(i, 8'h5A);
    end
    push_exp(1, 4);
    run_job(1, 0, 0);
    chk("t6_done_cyc", 64'(r_done), 64'd5);
    for (int i = 0; i < LANES; i++) sz[i*8 +: 8] = 8'(fq[i].size());
    chk("t6_left", 64'(sz), 64'h01010101);
    for (int i = 0; i < LANES; i++) fq[i].delete();
    refresh();
    repeat (2) cyc_step();

    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
